fc2_ifm_feeder: RTL and testbench

//  Upstream side of the FC2 start/end handshake. Collects the IFM_DEPTH FC1 outputs into a register bank.

---
 rtl/lenet_fc_pkg.sv | 16 +
 rtl/ifm_bank.sv | 38 +++
 rtl/fc2_ifm_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_fc2_ifm_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_fc_pkg.sv
// Shared definitions for the LeNet fully-connected stages.
// Holds the FC layer geometry and the FC2 input-feeder state encoding.
package lenet_fc_pkg;

    localparam int FC_DATA_WIDTH = 32;
    localparam int FC1_OUT_DEPTH = 84;
    localparam int FC2_OUT_DEPTH = 10;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HANDOFF = 2'd1,
        BUSY    = 2'd2,
        PENDING = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/ifm_bank.sv
// IFM register bank: DEPTH x DATA_WIDTH register file.
// Ports:
//   clk, reset   clock and asynchronous active-high reset (clears all words)
//   we, waddr,   synchronous write port
//   wdata
//   raddr        combinational read address; addresses >= DEPTH read as 0
//   rdata        word at raddr
module ifm_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 84,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && ({1'b0, waddr} < DEPTH_C)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH_C) ? mem[raddr] : '0;

endmodule

// File: rtl/fc2_ifm_feeder.sv
// FC2 input feeder: collects IFM_DEPTH FC1 output words into a bank, then
// hands the bank to the FC2 control unit via the start/end level handshake
// and serves rd_data[rd_sel] until the control unit releases it.
//
// Build option: FC2_IFM_DOUBLE_BUFFER_EN
//   defined   - two banks; FC1 fills the write bank while FC2 reads the other.
//   undefined - single bank; writes are blocked from fill end until release.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   wr_valid/data   FC1 word input, accepted when wr_valid & wr_ready
//   wr_ready        bank can accept a word
//   start_next      frame ready, level to FC2 control unit start
//   end_from_next   FC2 idle level (1 = idle, 0 = working)
//   rd_sel/rd_data  combinational read of the bank owned by FC2
//   frames_sent     completed handoffs, wraps at 2^16
//   wr_overflow     sticky: wr_valid seen while wr_ready = 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// FILL    | FC2 idle, no frame pending; FC1 filling the (write) bank
// HANDOFF | start_next high, waiting for FC2 to drop end_from_next
// BUSY    | FC2 working on the frame, waiting for end_from_next = 1
// PENDING | FC2 working and the write bank is full (double buffer only)
module fc2_ifm_feeder
    import lenet_fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int IFM_DEPTH  = FC1_OUT_DEPTH,
    parameter int ADDR_W     = $clog2(IFM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  start_next,
    input  logic                  end_from_next,
    input  logic [ADDR_W-1:0]     rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [15:0]           frames_sent,
    output logic                  wr_overflow
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(IFM_DEPTH - 1);

    feeder_state_t     state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic              last_accept;

    assign accept      = wr_valid & wr_ready;
    assign last_accept = accept && (wr_ptr == LAST_PTR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (accept) begin
            wr_ptr <= last_accept ? '0 : wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            wr_overflow <= 1'b1;
        end
    end

`ifdef FC2_IFM_DOUBLE_BUFFER_EN
    // bsel names the write bank; FC2 always reads the other one.
    logic                  bsel;
    logic                  wfull;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            wr_ready    <= 1'b1;
            start_next  <= 1'b0;
            frames_sent <= '0;
            bsel        <= 1'b0;
            wfull       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    // FC2 is idle, so a completed bank is handed over at once.
                    if (last_accept) begin
                        bsel       <= ~bsel;
                        state      <= HANDOFF;
                        start_next <= 1'b1;
                    end
                end
                HANDOFF: begin
                    if (last_accept) begin
                        wfull    <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                    if (!end_from_next) begin
                        start_next <= 1'b0;
                        state      <= (wfull || last_accept) ? PENDING : BUSY;
                    end
                end
                BUSY: begin
                    if (end_from_next) begin
                        frames_sent <= frames_sent + 16'd1;
                        if (last_accept) begin
                            bsel       <= ~bsel;
                            state      <= HANDOFF;
                            start_next <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end else if (last_accept) begin
                        wfull    <= 1'b1;
                        wr_ready <= 1'b0;
                        state    <= PENDING;
                    end
                end
                PENDING: begin
                    if (end_from_next) begin
                        frames_sent <= frames_sent + 16'd1;
                        bsel        <= ~bsel;
                        wfull       <= 1'b0;
                        wr_ready    <= 1'b1;
                        start_next  <= 1'b1;
                        state       <= HANDOFF;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (accept & ~bsel),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_sel),
        .rdata (rdata0)
    );

    ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (accept & bsel),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_sel),
        .rdata (rdata1)
    );

    assign rd_data = bsel ? rdata0 : rdata1;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            wr_ready    <= 1'b1;
            start_next  <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (last_accept) begin
                        state      <= HANDOFF;
                        wr_ready   <= 1'b0;
                        start_next <= 1'b1;
                    end
                end
                HANDOFF: begin
                    if (!end_from_next) begin
                        state      <= BUSY;
                        start_next <= 1'b0;
                    end
                end
                BUSY: begin
                    // wr_ready is still 0 on this edge, so a coincident word is refused.
                    if (end_from_next) begin
                        state       <= FILL;
                        wr_ready    <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_sel),
        .rdata (rd_data)
    );
`endif

endmodule

// File: tb/tb_fc2_ifm_feeder.sv
// Bench for fc2_ifm_feeder: random frames and FC2 handshake timing checked
// against a frame-level reference (expected bank contents, handoff count,
// sticky overflow flag).
module tb_fc2_ifm_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 84;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          start_next;
    logic          end_from_next;
    logic [AW-1:0] rd_sel;
    logic [DW-1:0] rd_data;
    logic [15:0]   frames_sent;
    logic          wr_overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fill_mem [DEPTH];
    logic [DW-1:0] rd_mem   [DEPTH];
    int            exp_frames;
    bit            exp_ovf;

    always #5 clk = ~clk;

    fc2_ifm_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .start_next    (start_next),
        .end_from_next (end_from_next),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .frames_sent   (frames_sent),
        .wr_overflow   (wr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input int sel);
        return (sel < DEPTH) ? rd_mem[sel] : 32'd0;
    endfunction

    task automatic read_chk(input string tag, input int sel);
        rd_sel = AW'(sel);
        #1;
        chk(tag, rd_data, ref_rd(sel));
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            fill_mem[i] = '0;
            rd_mem[i]   = '0;
        end
        exp_frames = 0;
        exp_ovf    = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid      = 1'b0;
        wr_data       = '0;
        end_from_next = 1'b1;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
        chk("rst_start_next", start_next, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_frames", frames_sent, 0);
        chk("rst_overflow", wr_overflow, 0);
        read_chk("rst_rd0", 0);
    endtask

    // kind: 0 = 3*i, 1 = random, 2 = 1000+i
    task automatic write_frame(input int kind, input int nwords, input bit gaps);
        logic [DW-1:0] w;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                tick();
            end
            case (kind)
                0:       w = DW'(3 * i);
                2:       w = DW'(1000 + i);
                default: w = $urandom;
            endcase
            chk("fill_wr_ready", wr_ready, 1);
            if (i == nwords - 1) chk("early_start", start_next, 0);
            wr_valid = 1'b1;
            wr_data  = w;
            tick();
            fill_mem[i] = w;
`ifndef FC2_IFM_DOUBLE_BUFFER_EN
            rd_mem[i] = w;
`endif
        end
        wr_valid = 1'b0;
    endtask

    // Entered one cycle after the last accept, with the frame in HANDOFF.
    task automatic fc2_frame(input int handoff_wait, input int busy_len, input bit poke);
        chk("handoff_start", start_next, 1);
        chk("handoff_wr_ready", wr_ready, 0);
        for (int c = 0; c < handoff_wait; c++) begin
            tick();
            chk("hold_start", start_next, 1);
            chk("hold_frames", frames_sent, 16'(exp_frames));
            chk("hold_wr_ready", wr_ready, 0);
        end
        end_from_next = 1'b0;
        tick();
        chk("ack_start_drop", start_next, 0);
        for (int c = 0; c < busy_len; c++) begin
            wr_valid = poke && (c % 7 == 3);
            wr_data  = $urandom;
            read_chk("busy_rd", $urandom_range(0, 127));
            tick();
            if (wr_valid) exp_ovf = 1'b1;
            wr_valid = 1'b0;
            chk("busy_wr_ready", wr_ready, 0);
            chk("busy_start", start_next, 0);
        end
        end_from_next = 1'b1;
        wr_valid      = poke;
        wr_data       = $urandom;
        tick();
        if (poke) exp_ovf = 1'b1;
        exp_frames++;
        wr_valid = 1'b0;
        chk("release_wr_ready", wr_ready, 1);
        chk("release_frames", frames_sent, 16'(exp_frames));
        chk("release_start", start_next, 0);
        chk("overflow", wr_overflow, 32'(exp_ovf));
        for (int k = 0; k < 4; k++) read_chk("post_rd", $urandom_range(0, DEPTH - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd_sel = '0;
        do_reset();
`ifndef FC2_IFM_DOUBLE_BUFFER_EN
        // back-to-back 3*i frame, then the basic handshake
        write_frame(0, DEPTH, 1'b0);
        chk("t1_start", start_next, 1);
        chk("t1_wr_ready", wr_ready, 0);
        read_chk("t1_rd5", 5);
        chk("t1_rd5_val", rd_data, 15);
        read_chk("t1_rd83", 83);
        chk("t1_rd83_val", rd_data, 249);
        read_chk("t1_rd84", 84);
        read_chk("t1_rd127", 127);
        fc2_frame(0, 85, 1'b0);

        // long HANDOFF wait with end_from_next held idle
        write_frame(1, DEPTH, 1'b1);
        fc2_frame(200, 20, 1'b0);

        // writes attempted while the bank is owned by FC2
        write_frame(1, DEPTH, 1'b0);
        fc2_frame(0, 30, 1'b1);
        chk("ovf_sticky", wr_overflow, 1);

        // next frame must start at word 0 after the refused word
        write_frame(1, DEPTH, 1'b1);
        chk("ovf_still_set", wr_overflow, 1);
        fc2_frame(3, 12, 1'b0);

        // reset mid-frame
        write_frame(1, 40, 1'b0);
        chk("mid_start", start_next, 0);
        do_reset();
        write_frame(1, DEPTH, 1'b1);
        fc2_frame(2, 10, 1'b0);

        for (int r = 0; r < 3; r++) begin
            write_frame(1, DEPTH, 1'b1);
            fc2_frame($urandom_range(0, 5), $urandom_range(1, 40), 1'($urandom_range(0, 1)));
        end
`else
        // frame A completes while idle: immediate handoff, writes stay open
        write_frame(0, DEPTH, 1'b0);
        chk("dbA_start", start_next, 1);
        chk("dbA_wr_ready", wr_ready, 1);
        for (int i = 0; i < DEPTH; i++) rd_mem[i] = fill_mem[i];
        read_chk("dbA_rd5", 5);
        chk("dbA_rd5_val", rd_data, 15);
        end_from_next = 1'b0;
        tick();
        chk("dbA_ack", start_next, 0);
        // frame B fills while A is busy
        write_frame(2, DEPTH, 1'b0);
        chk("dbB_full_wr_ready", wr_ready, 0);
        chk("dbB_start_low", start_next, 0);
        read_chk("dbB_rdA83", 83);
        chk("dbB_rdA83_val", rd_data, 249);
        end_from_next = 1'b1;
        tick();
        exp_frames++;
        for (int i = 0; i < DEPTH; i++) rd_mem[i] = fill_mem[i];
        chk("dbB_start", start_next, 1);
        chk("dbB_frames", frames_sent, 16'(exp_frames));
        chk("dbB_wr_ready", wr_ready, 1);
        read_chk("dbB_rd0", 0);
        chk("dbB_rd0_val", rd_data, 1000);
        end_from_next = 1'b0;
        tick();
        chk("dbB_ack", start_next, 0);
        end_from_next = 1'b1;
        tick();
        exp_frames++;
        chk("dbB_release_frames", frames_sent, 16'(exp_frames));
        chk("dbB_release_start", start_next, 0);
        chk("db_overflow", wr_overflow, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
